ring_node_vc: RTL and testbench

Parametrised successor to the single-FIFO ring node: one ring stop with NUM_CH local injection queues, round-robin injection arbitration, and slot reuse (a packet removed at this node frees its slot for injection in the same cycle). Ejection uses a valid/ready handshake. A unicast packet that cannot be ejected is deflected around the ring and its retry count is incremented. Starvation is detected and reported. It sits between the ring pipeline and the local cache/directory agent.

---
 rtl/ring_node_vc.sv | 276 +++++++++++++++++++++++++++
 tb/tb_ring_node_vc.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_node_vc.sv
// Ring stop with NUM_CH round-robin injection queues, slot reuse, deflection on ejection backpressure
// and starvation detection. Define RING_NODE_VC_STATS_EN to add the 16-bit statistics counters.
module ring_node_vc #(
    parameter int NODE_ID      = 0,
    parameter int NODE_W       = 4,
    parameter int CMD_W        = 3,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int NUM_CH       = 2,
    parameter int OQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                                          clock,
    input  logic                                          reset_n,
    input  logic                                          enable,
    input  logic                                          rin_valid,
    input  logic                                          rin_bcast,
    input  logic [NODE_W-1:0]                             rin_src,
    input  logic [NODE_W-1:0]                             rin_dest,
    input  logic [CMD_W-1:0]                              rin_cmd,
    input  logic [ADDR_W-1:0]                             rin_addr,
    input  logic [DATA_W-1:0]                             rin_data,
    input  logic [3:0]                                    rin_retry,
    output logic                                          rout_valid,
    output logic                                          rout_bcast,
    output logic [NODE_W-1:0]                             rout_src,
    output logic [NODE_W-1:0]                             rout_dest,
    output logic [CMD_W-1:0]                              rout_cmd,
    output logic [ADDR_W-1:0]                             rout_addr,
    output logic [DATA_W-1:0]                             rout_data,
    output logic [3:0]                                    rout_retry,
    input  logic                                          inj_valid,
    output logic                                          inj_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] inj_ch,
    input  logic [NODE_W-1:0]                             inj_dest,
    input  logic                                          inj_bcast,
    input  logic [CMD_W-1:0]                              inj_cmd,
    input  logic [ADDR_W-1:0]                             inj_addr,
    input  logic [DATA_W-1:0]                             inj_data,
    output logic                                          ej_valid,
    input  logic                                          ej_ready,
    output logic [NODE_W-1:0]                             ej_src,
    output logic                                          ej_bcast,
    output logic [CMD_W-1:0]                              ej_cmd,
    output logic [ADDR_W-1:0]                             ej_addr,
    output logic [DATA_W-1:0]                             ej_data,
`ifdef RING_NODE_VC_STATS_EN
    output logic [15:0]                                   stat_inj,
    output logic [15:0]                                   stat_ej,
    output logic [15:0]                                   stat_defl,
    output logic [15:0]                                   stat_bmiss,
`endif
    output logic                                          starve,
    output logic                                          retry_sat
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = $clog2(OQ_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [NODE_W-1:0] MY_ID = NODE_W'(NODE_ID);
    localparam logic [SC_W-1:0]   SC_MAX = SC_W'(STARVE_LIMIT);

    typedef struct packed {
        logic [NODE_W-1:0] dest;
        logic              bcast;
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } qEntry_t;

    typedef struct packed {
        logic              valid;
        logic              bcast;
        logic [NODE_W-1:0] src;
        logic [NODE_W-1:0] dest;
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [3:0]        retry;
    } slot_t;

    qEntry_t           r_qMem  [NUM_CH][OQ_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr [NUM_CH];
    logic [PTR_W-1:0]  r_rdPtr [NUM_CH];
    logic [CH_W-1:0]   r_rrPtr;
    slot_t             r_rout;
    logic              r_ejValid;
    logic              r_ejBcast;
    logic [NODE_W-1:0] r_ejSrc;
    logic [CMD_W-1:0]  r_ejCmd;
    logic [ADDR_W-1:0] r_ejAddr;
    logic [DATA_W-1:0] r_ejData;
    logic [SC_W-1:0]   r_starveCnt;
    logic              r_retrySat;

    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_full;
    logic              w_anyPending;
    logic [CH_W-1:0]   w_gnt;
    logic              w_gntFound;
    qEntry_t           w_head;
    slot_t             w_routNext;
    logic              w_push;
    logic              w_pop;
    logic              w_ejFree;
    logic              w_isUni;
    logic              w_ejectUni;
    logic              w_deflect;
    logic              w_bcOther;
    logic              w_bcOwn;
    logic              w_capture;
    logic              w_slotFree;

    // One extra pointer bit distinguishes full from empty when the index bits match.
    always_comb begin
        w_empty = '0;
        w_full  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_empty[c] = (r_wrPtr[c] == r_rdPtr[c]);
            w_full[c]  = (r_wrPtr[c][PTR_W-1] != r_rdPtr[c][PTR_W-1]) &&
                         (r_wrPtr[c][IDX_W-1:0] == r_rdPtr[c][IDX_W-1:0]);
        end
    end

    assign w_anyPending = |(~w_empty);
    assign inj_ready    = reset_n && (int'(inj_ch) < NUM_CH) && !w_full[inj_ch];
    assign w_push       = inj_valid && inj_ready;

    always_comb begin
        w_gnt      = '0;
        w_gntFound = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!w_gntFound && !w_empty[(int'(r_rrPtr) + i) % NUM_CH]) begin
                w_gnt      = CH_W'((int'(r_rrPtr) + i) % NUM_CH);
                w_gntFound = 1'b1;
            end
        end
    end

    assign w_head     = r_qMem[w_gnt][r_rdPtr[w_gnt][IDX_W-1:0]];
    assign w_ejFree   = !r_ejValid || ej_ready;
    assign w_isUni    = rin_valid && !rin_bcast && (rin_dest == MY_ID);
    assign w_ejectUni = w_isUni && w_ejFree;
    assign w_deflect  = w_isUni && !w_ejFree;
    assign w_bcOther  = rin_valid && rin_bcast && (rin_src != MY_ID);
    assign w_bcOwn    = rin_valid && rin_bcast && (rin_src == MY_ID);
    assign w_capture  = enable && (w_ejectUni || (w_bcOther && w_ejFree));
    assign w_slotFree = !rin_valid || w_ejectUni || w_bcOwn;
    assign w_pop      = enable && w_slotFree && w_anyPending;

    always_comb begin
        w_routNext = '0;
        if (w_pop) begin
            w_routNext.valid = 1'b1;
            w_routNext.bcast = w_head.bcast;
            w_routNext.src   = MY_ID;
            w_routNext.dest  = w_head.dest;
            w_routNext.cmd   = w_head.cmd;
            w_routNext.addr  = w_head.addr;
            w_routNext.data  = w_head.data;
        end else if (!w_slotFree) begin
            w_routNext = '{rin_valid, rin_bcast, rin_src, rin_dest, rin_cmd, rin_addr, rin_data, rin_retry};
            if (w_deflect && (rin_retry != 4'hF)) begin
                w_routNext.retry = rin_retry + 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_qMem[inj_ch][r_wrPtr[inj_ch][IDX_W-1:0]] <= '{inj_dest, inj_bcast, inj_cmd, inj_addr, inj_data};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_wrPtr[c] <= '0;
                r_rdPtr[c] <= '0;
            end
            r_rrPtr <= CH_W'(NUM_CH - 1);
        end else begin
            if (w_push) begin
                r_wrPtr[inj_ch] <= r_wrPtr[inj_ch] + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr[w_gnt] <= r_rdPtr[w_gnt] + PTR_W'(1);
                r_rrPtr        <= w_gnt;
            end
        end
    end

    // Ring-side state advances only when enabled; the ejection handshake keeps running regardless.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rout      <= '0;
            r_starveCnt <= '0;
            r_retrySat  <= 1'b0;
        end else begin
            r_retrySat <= enable && w_deflect && (rin_retry == 4'hF);
            if (enable) begin
                r_rout <= w_routNext;
                if (w_pop || !w_anyPending) begin
                    r_starveCnt <= '0;
                end else if (r_starveCnt != SC_MAX) begin
                    r_starveCnt <= r_starveCnt + SC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ejValid <= 1'b0;
            r_ejBcast <= 1'b0;
            r_ejSrc   <= '0;
            r_ejCmd   <= '0;
            r_ejAddr  <= '0;
            r_ejData  <= '0;
        end else if (w_capture) begin
            r_ejValid <= 1'b1;
            r_ejBcast <= rin_bcast;
            r_ejSrc   <= rin_src;
            r_ejCmd   <= rin_cmd;
            r_ejAddr  <= rin_addr;
            r_ejData  <= rin_data;
        end else if (r_ejValid && ej_ready) begin
            r_ejValid <= 1'b0;
        end
    end

`ifdef RING_NODE_VC_STATS_EN
    logic [15:0] r_statInj;
    logic [15:0] r_statEj;
    logic [15:0] r_statDefl;
    logic [15:0] r_statBmiss;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_statInj   <= '0;
            r_statEj    <= '0;
            r_statDefl  <= '0;
            r_statBmiss <= '0;
        end else begin
            if (w_pop)                                r_statInj   <= r_statInj + 16'd1;
            if (w_capture)                            r_statEj    <= r_statEj + 16'd1;
            if (enable && w_deflect)                  r_statDefl  <= r_statDefl + 16'd1;
            if (enable && w_bcOther && !w_ejFree)     r_statBmiss <= r_statBmiss + 16'd1;
        end
    end

    assign stat_inj   = r_statInj;
    assign stat_ej    = r_statEj;
    assign stat_defl  = r_statDefl;
    assign stat_bmiss = r_statBmiss;
`endif

    assign rout_valid = r_rout.valid;
    assign rout_bcast = r_rout.bcast;
    assign rout_src   = r_rout.src;
    assign rout_dest  = r_rout.dest;
    assign rout_cmd   = r_rout.cmd;
    assign rout_addr  = r_rout.addr;
    assign rout_data  = r_rout.data;
    assign rout_retry = r_rout.retry;
    assign ej_valid   = r_ejValid;
    assign ej_bcast   = r_ejBcast;
    assign ej_src     = r_ejSrc;
    assign ej_cmd     = r_ejCmd;
    assign ej_addr    = r_ejAddr;
    assign ej_data    = r_ejData;
    assign starve     = (r_starveCnt == SC_MAX);
    assign retry_sat  = r_retrySat;

endmodule

// File: tb/tb_ring_node_vc.sv
// Directed bench for ring_node_vc at NODE_ID=2: a per-cycle vector table for ejection/deflection/broadcast
// handling, then hand-written sequences for slot reuse, round-robin order, starvation and reset.
module tb_ring_node_vc;

    logic        clock = 1'b0;
    logic        reset_n, enable;
    logic        rin_valid, rin_bcast;
    logic [3:0]  rin_src, rin_dest, rin_retry;
    logic [2:0]  rin_cmd;
    logic [31:0] rin_addr;
    logic [63:0] rin_data;
    logic        rout_valid, rout_bcast;
    logic [3:0]  rout_src, rout_dest, rout_retry;
    logic [2:0]  rout_cmd;
    logic [31:0] rout_addr;
    logic [63:0] rout_data;
    logic        inj_valid, inj_ready, inj_ch, inj_bcast;
    logic [3:0]  inj_dest;
    logic [2:0]  inj_cmd;
    logic [31:0] inj_addr;
    logic [63:0] inj_data;
    logic        ej_valid, ej_ready, ej_bcast;
    logic [3:0]  ej_src;
    logic [2:0]  ej_cmd;
    logic [31:0] ej_addr;
    logic [63:0] ej_data;
    logic        starve, retry_sat;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ring_node_vc #(.NODE_ID(2)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .rin_valid(rin_valid), .rin_bcast(rin_bcast), .rin_src(rin_src), .rin_dest(rin_dest),
        .rin_cmd(rin_cmd), .rin_addr(rin_addr), .rin_data(rin_data), .rin_retry(rin_retry),
        .rout_valid(rout_valid), .rout_bcast(rout_bcast), .rout_src(rout_src), .rout_dest(rout_dest),
        .rout_cmd(rout_cmd), .rout_addr(rout_addr), .rout_data(rout_data), .rout_retry(rout_retry),
        .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_ch(inj_ch), .inj_dest(inj_dest),
        .inj_bcast(inj_bcast), .inj_cmd(inj_cmd), .inj_addr(inj_addr), .inj_data(inj_data),
        .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_src(ej_src), .ej_bcast(ej_bcast),
        .ej_cmd(ej_cmd), .ej_addr(ej_addr), .ej_data(ej_data),
        .starve(starve), .retry_sat(retry_sat)
    );

    typedef struct {
        logic        rv;
        logic        rb;
        logic [3:0]  src;
        logic [3:0]  dest;
        logic [2:0]  cmd;
        logic [31:0] addr;
        logic [3:0]  retry;
        logic        ejr;
        logic        eRoutValid;
        logic [3:0]  eRoutSrc;
        logic [3:0]  eRoutDest;
        logic [31:0] eRoutAddr;
        logic [3:0]  eRoutRetry;
        logic        eEjValid;
        logic [31:0] eEjAddr;
        logic        eRetrySat;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic rb, input logic [3:0] src, input logic [3:0] dest,
                                 input logic [2:0] cmd, input logic [31:0] addr, input logic [3:0] retry,
                                 input logic ejr);
        rin_valid = rv;
        rin_bcast = rb;
        rin_src   = src;
        rin_dest  = dest;
        rin_cmd   = cmd;
        rin_addr  = addr;
        rin_data  = {32'hDA7A0000, addr};
        rin_retry = retry;
        ej_ready  = ejr;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic passThrough();
        applyStimulus(1'b1, 1'b0, 4'd3, 4'd7, 3'd2, 32'h77, 4'd0, 1'b1);
    endtask

    task automatic idleRing();
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 32'h0, 4'd0, 1'b1);
    endtask

    task automatic pushWithTraffic(input logic ch, input logic [31:0] addr);
        inj_valid = 1'b1;
        inj_ch    = ch;
        inj_dest  = 4'd4;
        inj_bcast = 1'b0;
        inj_cmd   = 3'd2;
        inj_addr  = addr;
        inj_data  = {32'h0, addr};
        passThrough();
        tick();
        inj_valid = 1'b0;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        idleRing();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1,0,1,2,1,32'h100,0,1,  0,0,0,32'h0,0,    1,32'h100,0};
        vecs[1]  = '{0,0,0,0,0,32'h0,0,1,    0,0,0,32'h0,0,    0,32'h100,0};
        vecs[2]  = '{1,0,1,2,1,32'h200,0,0,  0,0,0,32'h0,0,    1,32'h200,0};
        vecs[3]  = '{1,0,1,2,1,32'h300,0,0,  1,1,2,32'h300,1,  1,32'h200,0};
        vecs[4]  = '{1,0,1,2,1,32'h400,15,0, 1,1,2,32'h400,15, 1,32'h200,1};
        vecs[5]  = '{0,0,0,0,0,32'h0,0,0,    0,0,0,32'h0,0,    1,32'h200,0};
        vecs[6]  = '{1,1,5,0,3,32'h500,0,1,  1,5,0,32'h500,0,  1,32'h500,0};
        vecs[7]  = '{1,1,5,0,3,32'h600,0,0,  1,5,0,32'h600,0,  1,32'h500,0};
        vecs[8]  = '{1,0,3,7,2,32'h700,3,1,  1,3,7,32'h700,3,  0,32'h500,0};
        vecs[9]  = '{1,1,2,0,4,32'h800,0,1,  0,0,0,32'h0,0,    0,32'h500,0};
        vecs[10] = '{1,0,1,2,1,32'h900,0,0,  0,0,0,32'h0,0,    1,32'h900,0};
        vecs[11] = '{1,0,1,2,1,32'hA00,14,0, 1,1,2,32'hA00,15, 1,32'h900,0};

        reset_n   = 1'b0;
        enable    = 1'b1;
        inj_valid = 1'b0;
        inj_ch    = 1'b0;
        inj_dest  = '0;
        inj_bcast = 1'b0;
        inj_cmd   = '0;
        inj_addr  = '0;
        inj_data  = '0;
        idleRing();
        tick();
        tick();
        checkOutput("reset.routValid", 64'(rout_valid), 64'd0);
        checkOutput("reset.ejValid", 64'(ej_valid), 64'd0);
        checkOutput("reset.starve", 64'(starve), 64'd0);
        checkOutput("reset.retrySat", 64'(retry_sat), 64'd0);
        checkOutput("reset.injReadyLow", 64'(inj_ready), 64'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("reset.injReadyHigh", 64'(inj_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rv, vecs[i].rb, vecs[i].src, vecs[i].dest, vecs[i].cmd,
                          vecs[i].addr, vecs[i].retry, vecs[i].ejr);
            tick();
            checkOutput($sformatf("v%0d.routValid", i), 64'(rout_valid), 64'(vecs[i].eRoutValid));
            checkOutput($sformatf("v%0d.routSrc", i), 64'(rout_src), 64'(vecs[i].eRoutSrc));
            checkOutput($sformatf("v%0d.routDest", i), 64'(rout_dest), 64'(vecs[i].eRoutDest));
            checkOutput($sformatf("v%0d.routAddr", i), 64'(rout_addr), 64'(vecs[i].eRoutAddr));
            checkOutput($sformatf("v%0d.routRetry", i), 64'(rout_retry), 64'(vecs[i].eRoutRetry));
            checkOutput($sformatf("v%0d.ejValid", i), 64'(ej_valid), 64'(vecs[i].eEjValid));
            checkOutput($sformatf("v%0d.ejAddr", i), 64'(ej_addr), 64'(vecs[i].eEjAddr));
            checkOutput($sformatf("v%0d.retrySat", i), 64'(retry_sat), 64'(vecs[i].eRetrySat));
        end

        // Own broadcast removed and its slot reused by a queued packet in the same cycle
        inj_valid = 1'b1;
        inj_ch    = 1'b0;
        inj_dest  = 4'd4;
        inj_cmd   = 3'd2;
        inj_addr  = 32'hB00;
        inj_data  = 64'hB00;
        idleRing();
        #1;
        checkOutput("reuse.injReady", 64'(inj_ready), 64'd1);
        tick();
        inj_valid = 1'b0;
        checkOutput("reuse.noBypass", 64'(rout_valid), 64'd0);
        applyStimulus(1'b1, 1'b1, 4'd2, 4'd0, 3'd4, 32'h800, 4'd0, 1'b1);
        tick();
        checkOutput("reuse.routValid", 64'(rout_valid), 64'd1);
        checkOutput("reuse.routSrc", 64'(rout_src), 64'd2);
        checkOutput("reuse.routDest", 64'(rout_dest), 64'd4);
        checkOutput("reuse.routAddr", 64'(rout_addr), 64'hB00);
        checkOutput("reuse.routRetry", 64'(rout_retry), 64'd0);

        // Round-robin order across two channels starting from pointer NUM_CH-1
        doReset();
        pushWithTraffic(1'b0, 32'hA0);
        pushWithTraffic(1'b0, 32'hA1);
        pushWithTraffic(1'b1, 32'hB0);
        pushWithTraffic(1'b1, 32'hB1);
        begin
            logic [31:0] order [4];
            order[0] = 32'hA0;
            order[1] = 32'hB0;
            order[2] = 32'hA1;
            order[3] = 32'hB1;
            idleRing();
            for (int k = 0; k < 4; k++) begin
                tick();
                checkOutput($sformatf("rr%0d.routAddr", k), 64'(rout_addr), 64'(order[k]));
                checkOutput($sformatf("rr%0d.routSrc", k), 64'(rout_src), 64'd2);
            end
        end
        tick();
        checkOutput("rr.drained", 64'(rout_valid), 64'd0);

        // Starvation: 16 enabled blocked cycles, freeze with enable low, then recover
        doReset();
        pushWithTraffic(1'b0, 32'hC0);
        passThrough();
        for (int k = 0; k < 15; k++) tick();
        checkOutput("starve.before", 64'(starve), 64'd0);
        tick();
        checkOutput("starve.set", 64'(starve), 64'd1);
        enable = 1'b0;
        idleRing();
        tick();
        checkOutput("freeze.starve", 64'(starve), 64'd1);
        checkOutput("freeze.routAddr", 64'(rout_addr), 64'h77);
        checkOutput("freeze.routSrc", 64'(rout_src), 64'd3);
        enable = 1'b1;
        tick();
        checkOutput("starve.injAddr", 64'(rout_addr), 64'hC0);
        checkOutput("starve.injSrc", 64'(rout_src), 64'd2);
        checkOutput("starve.cleared", 64'(starve), 64'd0);

        // Full queue backpressure per channel, then reset discards everything
        doReset();
        for (int k = 0; k < 4; k++) pushWithTraffic(1'b1, 32'hD0 + 32'(k));
        inj_ch = 1'b1;
        #1;
        checkOutput("full.ch1Ready", 64'(inj_ready), 64'd0);
        inj_ch = 1'b0;
        #1;
        checkOutput("full.ch0Ready", 64'(inj_ready), 64'd1);
        applyStimulus(1'b1, 1'b0, 4'd1, 4'd2, 3'd1, 32'hD00, 4'd0, 1'b0);
        tick();
        checkOutput("full.ejValid", 64'(ej_valid), 64'd1);
        reset_n = 1'b0;
        passThrough();
        tick();
        checkOutput("midReset.routValid", 64'(rout_valid), 64'd0);
        checkOutput("midReset.ejValid", 64'(ej_valid), 64'd0);
        checkOutput("midReset.injReady", 64'(inj_ready), 64'd0);
        reset_n = 1'b1;
        inj_ch  = 1'b1;
        idleRing();
        #1;
        checkOutput("postReset.ch1Ready", 64'(inj_ready), 64'd1);
        tick();
        checkOutput("postReset.queuesEmpty", 64'(rout_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
